// File: rtl/xm_mem_if.sv
// Request/response bundle between the XMakina core controller and the memory responder.
interface xm_mem_if #(
  parameter int WORD = 16
);
  logic            memEn_i;
  logic            memRW_i;
  logic            byteOp_i;
  logic [WORD-1:0] addr_i;
  logic [WORD-1:0] wrData_i;
  logic [WORD-1:0] rdData_o;
  logic            memBusy_o;
  logic            memErr_o;

  modport slave (
    input  memEn_i, memRW_i, byteOp_i, addr_i, wrData_i,
    output rdData_o, memBusy_o, memErr_o
  );

  modport master (
    output memEn_i, memRW_i, byteOp_i, addr_i, wrData_i,
    input  rdData_o, memBusy_o, memErr_o
  );
endinterface

// File: rtl/xm_mem_responder.sv
// Wait-state memory responder: latches one request, stays busy for WAIT_STATES+1 edges,
// then performs a byte/word access on a little-endian RAM and reports misuse via memErr_o.
module xm_mem_responder #(
  parameter int WORD        = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input logic      clk_i,
  input logic      arst_ni,
  xm_mem_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic            rw_q;
  logic            byte_q;
  logic [WORD-1:0] addr_q;
  logic [WORD-1:0] wdata_q;
  logic [WORD-1:0] rdata_q;
  logic            busy_q;
  logic            err_q;

  logic [WORD-1:0] mem [DEPTH];

  logic [WORD-2:0] idx;
  logic            lane;
  logic            bad;
  logic            done;
  logic [AW-1:0]   ram_a;
  logic [WORD-1:0] ram_rd;
  logic [WORD-1:0] rd_byte;
  logic [1:0]      lane_we;
  logic [1:0][7:0] wr_lane;

  assign idx     = addr_q[WORD-1:1];
  assign lane    = addr_q[0];
  assign bad     = (!byte_q && lane) || (32'(idx) >= 32'(DEPTH));
  assign done    = (state_q == BUSY) && (cnt_q == 4'd0);
  assign ram_a   = idx[AW-1:0];
  assign ram_rd  = mem[ram_a];
  assign rd_byte = {{(WORD-8){1'b0}}, (lane ? ram_rd[15:8] : ram_rd[7:0])};

  // Byte writes replicate wrData[7:0] onto whichever lane addr[0] selects.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      assign lane_we[gi] = done && rw_q && !bad && (!byte_q || (lane == 1'(gi)));
      assign wr_lane[gi] = byte_q ? wdata_q[7:0] : wdata_q[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 2; i++) begin
      if (lane_we[i]) begin
        mem[ram_a][8*i +: 8] <= wr_lane[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.memEn_i) begin
            rw_q    <= bus.memRW_i;
            byte_q  <= bus.byteOp_i;
            addr_q  <= bus.addr_i;
            wdata_q <= bus.wrData_i;
            cnt_q   <= 4'(WAIT_STATES);
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (bad) begin
              err_q <= 1'b1;
            end else if (!rw_q) begin
              rdata_q <= byte_q ? rd_byte : ram_rd;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rdData_o  = rdata_q;
  assign bus.memBusy_o = busy_q;
  assign bus.memErr_o  = err_q;
endmodule
